adder_multicycle_nb: RTL and testbench
======================================

ADDER_MULTICYCLE_NB -- requirements
Module: adder_multicycle_nb

Interface
REQ-001 SHALL have parameter nbits, default 16: total operand/sum width.
REQ-002 SHALL have parameter cbits, default 4: chunk width added per cycle; nbits SHALL be a positive multiple of cbits; nchunks = nbits/cbits.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port in_val, input, 1: operands valid.
REQ-006 SHALL have port in_rdy, output, 1: block can accept operands.
REQ-007 SHALL have ports in0 and in1, input, nbits: unsigned or two's-complement addends.
REQ-008 SHALL have port cin, input, 1: carry-in.
REQ-009 SHALL have port out_val, output, 1: result valid.
REQ-010 SHALL have port out_rdy, input, 1: consumer accepts result.
REQ-011 SHALL have port sum, output, nbits: in0 + in1 + cin modulo 2^nbits.
REQ-012 SHALL have port cout, output, 1: unsigned carry-out of bit nbits-1.
REQ-013 SHALL have port ovf, output, 1: signed overflow (carry into MSB XOR carry out of MSB).

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 SHALL drive in_rdy = 1 only in IDLE, out_val = 1 only in DONE.
REQ-016 IDLE: on in_val && in_rdy at an edge, SHALL latch in0, in1, cin, clear chunk index to 0, go to CALC; otherwise stay.
REQ-017 CALC: each edge SHALL add chunk [idx*cbits +: cbits] of both operands plus carry register, write that chunk of sum register, update carry register, increment idx.
REQ-018 CALC: on the edge processing idx = nchunks-1, SHALL capture cout and ovf and go to DONE.
REQ-019 Latency: out_val SHALL first be high exactly nchunks cycles after the accepting edge (4 cycles at defaults).
REQ-020 DONE: sum, cout, ovf SHALL hold stable while out_val && !out_rdy.
REQ-021 DONE: on out_rdy at an edge, SHALL go to IDLE; a new accept SHALL NOT occur on that same edge (in_rdy low in DONE).
REQ-022 Input changes on in0/in1/cin outside the accepting edge SHALL NOT affect the result.
REQ-023 nchunks = 1 SHALL work: CALC lasts one cycle.
REQ-024 Wrap-around: result bits above nbits SHALL be discarded; only cout reports them.
REQ-025 Chunk index SHALL be $clog2(nchunks) bits wide (minimum 1) and never exceed nchunks-1.

Reset
REQ-026 rst_n low at an edge SHALL force IDLE, idx 0, carry register 0, sum 0, cout 0, ovf 0, out_val 0, regardless of state (mid-CALC or DONE aborts and discards operation).
REQ-027 in_rdy SHALL be 1 in the first cycle after rst_n is sampled low; in_val SHALL be ignored on any edge where rst_n is low.

Structure
REQ-028 State enum (IDLE, CALC, DONE) SHALL live in shared package adder_pkg.
REQ-029 Chunk addition SHALL be one sub-module, adder_chunk_nb (parameter cbits; in0, in1, cin -> sum, cout, plus carry into its MSB for ovf), combinational, instantiated once.
REQ-030 Control FSM and datapath registers SHALL be in adder_multicycle_nb; no other sub-modules.

Verification (nbits=16, cbits=4 unless stated)
REQ-031 Reset then 0x0000 + 0x0000, cin 0 -> out_val after 4 cycles, sum 0x0000, cout 0, ovf 0.
REQ-032 0xFFFF + 0x0001, cin 0 -> sum 0x0000, cout 1, ovf 0 (carry ripples through all 4 chunks).
REQ-033 0x7FFF + 0x0000, cin 1 -> sum 0x8000, cout 0, ovf 1; 0x8000 + 0x8000, cin 0 -> sum 0x0000, cout 1, ovf 1.
REQ-034 0x1234 + 0x4321, cin 0, out_rdy held low 5 cycles -> out_val and sum 0x5555 stable all 5 cycles, in_rdy 0; out_rdy 1 -> IDLE next cycle, in_rdy 1.
REQ-035 Accept 0xABCD + 0x1111, assert rst_n low after 2 CALC cycles -> next cycle IDLE, out_val 0, sum 0; following accept 0x0003 + 0x0004 -> sum 0x0007.
REQ-036 Parameter sweep nbits=8,cbits=8 and nbits=12,cbits=3 with 100 random operands -> sum/cout/ovf match reference model; latency 1 and 4 cycles respectively.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types for the multicycle chunked adder: FSM state encoding and
// index-width helper used to size the chunk counter.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-chunk adder still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_chunk_nb.sv
// Combinational cbits-wide adder slice; also exposes the carry into its MSB
// so the top level can form signed overflow on the last chunk.
module adder_chunk_nb #(
    parameter int cbits = 4
) (
    input  logic [cbits-1:0] in0,
    input  logic [cbits-1:0] in1,
    input  logic             cin,
    output logic [cbits-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [cbits:0] full;

    assign full = {1'b0, in0} + {1'b0, in1} + {{cbits{1'b0}}, cin};
    assign sum  = full[cbits-1:0];
    assign cout = full[cbits];
    // The MSB sum bit is a^b^carry_in, so the carry into it falls out by XOR.
    assign cmsb = full[cbits-1] ^ in0[cbits-1] ^ in1[cbits-1];

endmodule

// File: rtl/adder_multicycle_nb.sv
// Multicycle adder: latches operands, adds one cbits chunk per cycle with a
// registered carry, then presents sum/cout/ovf with a valid/ready handshake.
module adder_multicycle_nb
    import adder_pkg::*;
#(
    parameter int nbits = 16,
    parameter int cbits = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [nbits-1:0] in0,
    input  logic [nbits-1:0] in1,
    input  logic             cin,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [nbits-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNKS = nbits / cbits;
    localparam int IDXW    = idx_width(NCHUNKS);
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNKS - 1);

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [nbits-1:0] a_q, a_d;
    logic [nbits-1:0] b_q, b_d;
    logic [nbits-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [cbits-1:0] a_chunk, b_chunk, ch_sum;
    logic             ch_cout, ch_cmsb;

    // Select the operand chunk addressed by the current index.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNKS; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_chunk = a_q[i*cbits +: cbits];
                b_chunk = b_q[i*cbits +: cbits];
            end
        end
    end

    adder_chunk_nb #(
        .cbits (cbits)
    ) u_chunk (
        .in0  (a_chunk),
        .in1  (b_chunk),
        .cin  (carry_q),
        .sum  (ch_sum),
        .cout (ch_cout),
        .cmsb (ch_cmsb)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_val) begin
                    a_d     = in0;
                    b_d     = in1;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                for (int i = 0; i < NCHUNKS; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        sum_d[i*cbits +: cbits] = ch_sum;
                    end
                end
                carry_d = ch_cout;
                if (idx_q == LAST) begin
                    cout_d  = ch_cout;
                    ovf_d   = ch_cout ^ ch_cmsb;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                if (out_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_rdy  = (state_q == IDLE);
    assign out_val = (state_q == DONE);
    assign sum     = sum_q;
    assign cout    = cout_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_adder_multicycle_nb.sv
// Directed and randomized checks of adder_multicycle_nb at three
// parameterizations sharing one clock and reset.
module tb_adder_multicycle_nb;

    logic clk;
    logic rst_n;

    logic [2:0]  in_val_v;
    logic [2:0]  cin_v;
    logic [2:0]  out_rdy_v;
    logic [15:0] a_v [3];
    logic [15:0] b_v [3];

    logic        rdy16, rdy8, rdy12;
    logic        val16, val8, val12;
    logic        co16, co8, co12;
    logic        ov16, ov8, ov12;
    logic [15:0] s16;
    logic [7:0]  s8;
    logic [11:0] s12;

    logic [2:0] in_rdy_v, out_val_v, cout_v, ovf_v;
    assign in_rdy_v  = {rdy12, rdy8, rdy16};
    assign out_val_v = {val12, val8, val16};
    assign cout_v    = {co12, co8, co16};
    assign ovf_v     = {ov12, ov8, ov16};

    int n_cmp = 0;
    int n_bad = 0;

    adder_multicycle_nb #(.nbits(16), .cbits(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_val(in_val_v[0]), .in_rdy(rdy16),
        .in0(a_v[0]), .in1(b_v[0]), .cin(cin_v[0]), .out_val(val16),
        .out_rdy(out_rdy_v[0]), .sum(s16), .cout(co16), .ovf(ov16)
    );

    adder_multicycle_nb #(.nbits(8), .cbits(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_val(in_val_v[1]), .in_rdy(rdy8),
        .in0(a_v[1][7:0]), .in1(b_v[1][7:0]), .cin(cin_v[1]), .out_val(val8),
        .out_rdy(out_rdy_v[1]), .sum(s8), .cout(co8), .ovf(ov8)
    );

    adder_multicycle_nb #(.nbits(12), .cbits(3)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_val(in_val_v[2]), .in_rdy(rdy12),
        .in0(a_v[2][11:0]), .in1(b_v[2][11:0]), .cin(cin_v[2]), .out_val(val12),
        .out_rdy(out_rdy_v[2]), .sum(s12), .cout(co12), .ovf(ov12)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sum_of(input int k);
        case (k)
            0:       return s16;
            1:       return {8'h00, s8};
            default: return {4'h0, s12};
        endcase
    endfunction

    // Reference: full-width add, overflow from operand/result sign rule.
    task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                         input logic c, output logic [15:0] s,
                         output logic co, output logic ov);
        logic [31:0] full;
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        full = {16'h0, a} + {16'h0, b} + {31'h0, c};
        s    = 16'(full & mask);
        co   = full[w];
        ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    endtask

    task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input int hold, input logic [15:0] es,
                          input logic ec, input logic eo, input int elat,
                          input string tag);
        int lat;
        @(negedge clk);
        chk({tag, ".in_rdy_idle"}, 32'(in_rdy_v[k]), 32'd1);
        a_v[k] = a;
        b_v[k] = b;
        cin_v[k] = c;
        in_val_v[k] = 1'b1;
        @(negedge clk);
        in_val_v[k] = 1'b0;
        a_v[k] = ~a;
        b_v[k] = a ^ 16'h5a5a;
        cin_v[k] = ~c;
        chk({tag, ".in_rdy_busy"}, 32'(in_rdy_v[k]), 32'd0);
        lat = 0;
        while (!out_val_v[k] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(elat));
        chk({tag, ".sum"}, 32'(sum_of(k)), 32'(es));
        chk({tag, ".cout"}, 32'(cout_v[k]), 32'(ec));
        chk({tag, ".ovf"}, 32'(ovf_v[k]), 32'(eo));
        $display("op %s: %h + %h + %0d -> sum %h cout %0d ovf %0d lat %0d",
                 tag, a, b, c, sum_of(k), cout_v[k], ovf_v[k], lat);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold_val"}, 32'(out_val_v[k]), 32'd1);
            chk({tag, ".hold_sum"}, 32'(sum_of(k)), 32'(es));
            chk({tag, ".hold_rdy"}, 32'(in_rdy_v[k]), 32'd0);
        end
        out_rdy_v[k] = 1'b1;
        @(negedge clk);
        out_rdy_v[k] = 1'b0;
        chk({tag, ".pop_val"}, 32'(out_val_v[k]), 32'd0);
        chk({tag, ".pop_rdy"}, 32'(in_rdy_v[k]), 32'd1);
    endtask

    initial begin
        logic [15:0] ra, rb, rs;
        logic        rc, rco, rov;

        rst_n     = 1'b0;
        in_val_v  = '0;
        cin_v     = '0;
        out_rdy_v = '0;
        for (int k = 0; k < 3; k++) begin
            a_v[k] = '0;
            b_v[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset.in_rdy", 32'(in_rdy_v[k]), 32'd1);
            chk("reset.out_val", 32'(out_val_v[k]), 32'd0);
            chk("reset.sum", 32'(sum_of(k)), 32'd0);
        end
        chk("reset.cout", 32'(cout_v), 32'd0);
        chk("reset.ovf", 32'(ovf_v), 32'd0);
        rst_n = 1'b1;

        run_op(0, 16'h0000, 16'h0000, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 4, "zero");
        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0, 4, "ripple");
        run_op(0, 16'h7FFF, 16'h0000, 1'b1, 0, 16'h8000, 1'b0, 1'b1, 4, "posovf");
        run_op(0, 16'h8000, 16'h8000, 1'b0, 0, 16'h0000, 1'b1, 1'b1, 4, "negovf");
        run_op(0, 16'h1234, 16'h4321, 1'b0, 5, 16'h5555, 1'b0, 1'b0, 4, "stall");

        // Abort mid-calculation with reset; in_val asserted on the reset edge.
        @(negedge clk);
        a_v[0] = 16'hABCD;
        b_v[0] = 16'h1111;
        cin_v[0] = 1'b0;
        in_val_v[0] = 1'b1;
        @(negedge clk);
        in_val_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        in_val_v[0] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        in_val_v[0] = 1'b0;
        chk("abort.in_rdy", 32'(in_rdy_v[0]), 32'd1);
        chk("abort.out_val", 32'(out_val_v[0]), 32'd0);
        chk("abort.sum", 32'(sum_of(0)), 32'd0);
        @(negedge clk);
        chk("abort.still_idle", 32'(in_rdy_v[0]), 32'd1);
        $display("op abort: reset during CALC, in_rdy %0d sum %h", in_rdy_v[0], sum_of(0));
        run_op(0, 16'h0003, 16'h0004, 1'b0, 0, 16'h0007, 1'b0, 1'b0, 4, "after_abort");

        run_op(1, 16'h00FF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0, 1, "w8_wrap");
        run_op(2, 16'h07FF, 16'h0000, 1'b1, 0, 16'h0800, 1'b0, 1'b1, 4, "w12_ovf");

        for (int n = 0; n < 100; n++) begin
            ra = 16'($urandom) & 16'h00FF;
            rb = 16'($urandom) & 16'h00FF;
            rc = 1'($urandom);
            model(8, ra, rb, rc, rs, rco, rov);
            run_op(1, ra, rb, rc, 0, rs, rco, rov, 1, "rand8");
        end
        for (int n = 0; n < 100; n++) begin
            ra = 16'($urandom) & 16'h0FFF;
            rb = 16'($urandom) & 16'h0FFF;
            rc = 1'($urandom);
            model(12, ra, rb, rc, rs, rco, rov);
            run_op(2, ra, rb, rc, 0, rs, rco, rov, 4, "rand12");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
